// File: rtl/ex_mem_pkg.sv
// Shared widths, NOP/enable constants and the EX->MEM payload record
// used by the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int AluOpBus     = 8;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int StallEx  = 3;
    localparam int StallMem = 4;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'b0000_0000;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  InDelaySlot    = 1'b1;
    localparam logic                  NotInDelaySlot = 1'b0;

    // Everything that travels from EX to MEM, kept as one record so the
    // register stage can load, bubble or hold it in a single assignment.
    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
        logic [AluOpBus-1:0]   aluop;
        logic [RegBus-1:0]     mem_addr;
        logic [RegBus-1:0]     reg2;
        logic [RegBus-1:0]     excepttype;
        logic [RegBus-1:0]     current_inst_address;
        logic                  is_in_delayslot;
    } ex_mem_bundle_t;

    function automatic ex_mem_bundle_t bubble_bundle();
        ex_mem_bundle_t b;
        b.wd                   = NOPRegAddr;
        b.wreg                 = WriteDisable;
        b.wdata                = ZeroWord;
        b.whilo                = WriteDisable;
        b.hi                   = ZeroWord;
        b.lo                   = ZeroWord;
        b.aluop                = EXE_NOP_OP;
        b.mem_addr             = ZeroWord;
        b.reg2                 = ZeroWord;
        b.excepttype           = ZeroWord;
        b.current_inst_address = ZeroWord;
        b.is_in_delayslot      = NotInDelaySlot;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: stall/flush/bubble handling plus the two-cycle
// MADD/MSUB partial-product and count loop back to EX.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [RegAddrBus-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic                    ex_whilo,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic [AluOpBus-1:0]     ex_aluop,
    input  logic [RegBus-1:0]       ex_mem_addr,
    input  logic [RegBus-1:0]       ex_reg2,
    input  logic [RegBus-1:0]       ex_excepttype,
    input  logic [RegBus-1:0]       ex_current_inst_address,
    input  logic                    ex_is_in_delayslot,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [1:0]              cnt_i,
    output logic [RegAddrBus-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic                    mem_whilo,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic [AluOpBus-1:0]     mem_aluop,
    output logic [RegBus-1:0]       mem_mem_addr,
    output logic [RegBus-1:0]       mem_reg2,
    output logic [RegBus-1:0]       mem_excepttype,
    output logic [RegBus-1:0]       mem_current_inst_address,
    output logic                    mem_is_in_delayslot,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [1:0]              cnt_o
);

    ex_mem_bundle_t          w_ex_bundle;
    ex_mem_bundle_t          r_mem_bundle;
    logic [DoubleRegBus-1:0] r_hilo;
    logic [1:0]              r_cnt;
    logic                    w_ex_stall;
    logic                    w_mem_stall;
    logic                    w_stall_unused;

    // Only the EX and MEM stall bits matter to this stage.
    assign w_ex_stall     = stall[StallEx];
    assign w_mem_stall    = stall[StallMem];
    assign w_stall_unused = ^{stall[5], stall[2:0]};

    assign w_ex_bundle.wd                   = ex_wd;
    assign w_ex_bundle.wreg                 = ex_wreg;
    assign w_ex_bundle.wdata                = ex_wdata;
    assign w_ex_bundle.whilo                = ex_whilo;
    assign w_ex_bundle.hi                   = ex_hi;
    assign w_ex_bundle.lo                   = ex_lo;
    assign w_ex_bundle.aluop                = ex_aluop;
    assign w_ex_bundle.mem_addr             = ex_mem_addr;
    assign w_ex_bundle.reg2                 = ex_reg2;
    assign w_ex_bundle.excepttype           = ex_excepttype;
    assign w_ex_bundle.current_inst_address = ex_current_inst_address;
    assign w_ex_bundle.is_in_delayslot      = ex_is_in_delayslot;

    // The MAC partial product survives only while EX is stalled; any advance
    // or flush restarts the sequence from count 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_mem_bundle <= bubble_bundle();
            r_hilo       <= '0;
            r_cnt        <= 2'b00;
        end else if (flush) begin
            r_mem_bundle <= bubble_bundle();
            r_hilo       <= '0;
            r_cnt        <= 2'b00;
        end else if (w_ex_stall == Stop && w_mem_stall == NoStop) begin
            r_mem_bundle <= bubble_bundle();
            r_hilo       <= hilo_i;
            r_cnt        <= cnt_i;
        end else if (w_ex_stall == NoStop) begin
            r_mem_bundle <= w_ex_bundle;
            r_hilo       <= '0;
            r_cnt        <= 2'b00;
        end else begin
            r_hilo       <= hilo_i;
            r_cnt        <= cnt_i;
        end
    end

    assign mem_wd                   = r_mem_bundle.wd;
    assign mem_wreg                 = r_mem_bundle.wreg;
    assign mem_wdata                = r_mem_bundle.wdata;
    assign mem_whilo                = r_mem_bundle.whilo;
    assign mem_hi                   = r_mem_bundle.hi;
    assign mem_lo                   = r_mem_bundle.lo;
    assign mem_aluop                = r_mem_bundle.aluop;
    assign mem_mem_addr             = r_mem_bundle.mem_addr;
    assign mem_reg2                 = r_mem_bundle.reg2;
    assign mem_excepttype           = r_mem_bundle.excepttype;
    assign mem_current_inst_address = r_mem_bundle.current_inst_address;
    assign mem_is_in_delayslot      = r_mem_bundle.is_in_delayslot;
    assign hilo_o                   = r_hilo;
    assign cnt_o                    = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// Randomized bench for ex_mem: directed scenarios plus random stall/flush
// traffic compared against a next-state reference model of the stage.
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        dslot;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    rec_t        in_rec = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] mem_excepttype;
    logic [31:0] mem_current_inst_address;
    logic        mem_is_in_delayslot;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    // Reference state: what MEM should be holding and what EX gets back.
    rec_t        exp_rec = '0;
    logic [63:0] exp_hilo = '0;
    logic [1:0]  exp_cnt = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk                      (clk),
        .rst                      (rst),
        .stall                    (stall),
        .flush                    (flush),
        .ex_wd                    (in_rec.wd),
        .ex_wreg                  (in_rec.wreg),
        .ex_wdata                 (in_rec.wdata),
        .ex_whilo                 (in_rec.whilo),
        .ex_hi                    (in_rec.hi),
        .ex_lo                    (in_rec.lo),
        .ex_aluop                 (in_rec.aluop),
        .ex_mem_addr              (in_rec.addr),
        .ex_reg2                  (in_rec.reg2),
        .ex_excepttype            (in_rec.exc),
        .ex_current_inst_address  (in_rec.pc),
        .ex_is_in_delayslot       (in_rec.dslot),
        .hilo_i                   (hilo_i),
        .cnt_i                    (cnt_i),
        .mem_wd                   (mem_wd),
        .mem_wreg                 (mem_wreg),
        .mem_wdata                (mem_wdata),
        .mem_whilo                (mem_whilo),
        .mem_hi                   (mem_hi),
        .mem_lo                   (mem_lo),
        .mem_aluop                (mem_aluop),
        .mem_mem_addr             (mem_mem_addr),
        .mem_reg2                 (mem_reg2),
        .mem_excepttype           (mem_excepttype),
        .mem_current_inst_address (mem_current_inst_address),
        .mem_is_in_delayslot      (mem_is_in_delayslot),
        .hilo_o                   (hilo_o),
        .cnt_o                    (cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        logic [31:0] t;
        t = $urandom; r.wd = t[4:0]; r.wreg = t[5]; r.whilo = t[6]; r.dslot = t[7];
        r.aluop = t[15:8];
        r.wdata = $urandom; r.hi = $urandom; r.lo = $urandom;
        r.addr = $urandom; r.reg2 = $urandom; r.exc = $urandom; r.pc = $urandom;
        return r;
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".wd"},    {59'd0, mem_wd},              {59'd0, exp_rec.wd});
        chk({ph, ".wreg"},  {63'd0, mem_wreg},            {63'd0, exp_rec.wreg});
        chk({ph, ".wdata"}, {32'd0, mem_wdata},           {32'd0, exp_rec.wdata});
        chk({ph, ".whilo"}, {63'd0, mem_whilo},           {63'd0, exp_rec.whilo});
        chk({ph, ".hilo"},  {mem_hi, mem_lo},             {exp_rec.hi, exp_rec.lo});
        chk({ph, ".aluop"}, {56'd0, mem_aluop},           {56'd0, exp_rec.aluop});
        chk({ph, ".addr"},  {mem_mem_addr, mem_reg2},     {exp_rec.addr, exp_rec.reg2});
        chk({ph, ".exc"},   {mem_excepttype, mem_current_inst_address}, {exp_rec.exc, exp_rec.pc});
        chk({ph, ".dslot"}, {63'd0, mem_is_in_delayslot}, {63'd0, exp_rec.dslot});
        chk({ph, ".hilo_o"}, hilo_o,                      exp_hilo);
        chk({ph, ".cnt_o"}, {62'd0, cnt_o},               {62'd0, exp_cnt});
    endtask

    // Predict the stage contents after the coming edge from the inputs now
    // applied, then clock and compare.
    task automatic step(input string ph);
        if (rst || flush) begin
            exp_rec = '0; exp_hilo = '0; exp_cnt = '0;
        end else if (stall[3] == 1'b0) begin
            exp_rec = in_rec; exp_hilo = '0; exp_cnt = '0;
        end else begin
            if (stall[4] == 1'b0) exp_rec = '0;
            exp_hilo = hilo_i; exp_cnt = cnt_i;
        end
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d %s stall=%b flush=%b rst=%b wdata=%h cnt_o=%0d",
                 n_txn, ph, stall, flush, rst, mem_wdata, cnt_o);
        check_all(ph);
    endtask

    initial begin
        // Reset held with busy inputs: outputs zero before and across edges.
        in_rec = rand_rec(); in_rec.wreg = 1'b1; in_rec.aluop = 8'h23;
        hilo_i = 64'hDEAD_BEEF_0123_4567; cnt_i = 2'd1;
        #1 rst = 1'b1;
        #1 check_all("rst_async");
        step("rst_edge1");
        step("rst_edge2");
        chk("rst.aluop_nop", {56'd0, mem_aluop}, 64'd0);
        rst = 1'b0;

        // Advance.
        in_rec = rand_rec(); in_rec.wd = 5'd3; in_rec.wreg = 1'b1; in_rec.wdata = 32'h1234_5678;
        stall = 6'b000000; cnt_i = 2'd2;
        step("advance");
        chk("adv.wdata", {32'd0, mem_wdata}, 64'h1234_5678);
        chk("adv.wd", {59'd0, mem_wd}, 64'd3);
        chk("adv.cnt", {62'd0, cnt_o}, 64'd0);

        // Bubble.
        in_rec = rand_rec(); in_rec.wreg = 1'b1;
        stall = 6'b001111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        step("bubble");
        chk("bub.wreg", {63'd0, mem_wreg}, 64'd0);
        chk("bub.aluop", {56'd0, mem_aluop}, 64'd0);
        chk("bub.hilo", hilo_o, 64'h0000_0001_FFFF_FFFE);
        chk("bub.cnt", {62'd0, cnt_o}, 64'd1);

        // Hold for three cycles while EX changes underneath.
        in_rec = rand_rec(); in_rec.wdata = 32'hA5A5_A5A5; stall = 6'b000000;
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            in_rec.wdata = $urandom;
            step("hold");
            chk("hold.wdata", {32'd0, mem_wdata}, 64'hA5A5_A5A5);
        end

        // Flush beats an advance and a live MAC count.
        in_rec = rand_rec(); in_rec.wreg = 1'b1; stall = 6'b000000;
        flush = 1'b1; cnt_i = 2'd1; hilo_i = {$urandom, $urandom};
        step("flush");
        chk("flush.cnt", {62'd0, cnt_o}, 64'd0);
        chk("flush.wdata", {32'd0, mem_wdata}, 64'd0);
        flush = 1'b0;

        // Two-cycle MADD.
        in_rec = rand_rec(); stall = 6'b001111; cnt_i = 2'd1;
        hilo_i = 64'h0000_0002_8000_0000;
        step("madd1");
        chk("madd1.cnt", {62'd0, cnt_o}, 64'd1);
        chk("madd1.hilo", hilo_o, 64'h0000_0002_8000_0000);
        in_rec = rand_rec(); in_rec.whilo = 1'b1; in_rec.hi = 32'h0000_0003; in_rec.lo = 32'h7FFF_FFFF;
        stall = 6'b000000; cnt_i = 2'd2;
        step("madd2");
        chk("madd2.cnt", {62'd0, cnt_o}, 64'd0);
        chk("madd2.hilo", {mem_hi, mem_lo}, 64'h0000_0003_7FFF_FFFF);

        // Reset raised mid-cycle acts without an edge.
        #2 rst = 1'b1;
        exp_rec = '0; exp_hilo = '0; exp_cnt = '0;
        #1 check_all("rst_mid");
        #1 rst = 1'b0;
        step("post_rst");

        // Random traffic, including the unexpected EX-run/MEM-stop combination.
        for (int i = 0; i < 300; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: stall = 6'b000000;
                4, 5:       stall = 6'b001111;
                6, 7:       stall = 6'b011111;
                8:          stall = 6'b111111;
                default:    stall = 6'b010000;
            endcase
            flush  = ($urandom_range(0, 9) == 0);
            in_rec = rand_rec();
            hilo_i = {$urandom, $urandom};
            cnt_i  = 2'($urandom_range(0, 3));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
